// File: rtl/priority_encoder_pkg.sv
// Shared helpers for the priority encoder: tree sizing for non-power-of-two request widths.
package priority_encoder_pkg;

  function automatic int pe_pad_width(input int width);
    return 1 << $clog2(width);
  endfunction

endpackage

// File: rtl/pe_merge_node.sv
// 2:1 merge cell of the priority-encoder tree; selects the winning half and prepends its side bit.
module pe_merge_node #(
  parameter int IDX_W    = 1,
  parameter bit LSB_SIDE = 1'b0
) (
  input  logic             valid_hi,
  input  logic             valid_lo,
  input  logic [IDX_W-1:0] idx_hi,
  input  logic [IDX_W-1:0] idx_lo,
  output logic [IDX_W:0]   idx
);

  // Each search direction only looks at the valid of the half it prefers.
  logic unused_side;
  assign unused_side = LSB_SIDE ? valid_hi : valid_lo;

  if (LSB_SIDE) begin : g_lsb
    assign idx = valid_lo ? {1'b0, idx_lo} : {1'b1, idx_hi};
  end else begin : g_msb
    assign idx = valid_hi ? {1'b1, idx_hi} : {1'b0, idx_lo};
  end

endmodule

// File: rtl/priority_encoder.sv
// MSB/LSB set-bit finder for the rename free pool; log2-depth merge tree, optional output register.
module priority_encoder
  import priority_encoder_pkg::*;
#(
  parameter int WIDTH      = 64,
  parameter bit TWO_SIDE   = 1'b1,
  parameter bit REGISTERED = 1'b0,
  parameter int OUT_W      = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [OUT_W-1:0] out_MSB,
  output logic [OUT_W-1:0] out_LSB,
  output logic             valid
);

  localparam int LEVELS = $clog2(WIDTH);
  localparam int PAD_W  = pe_pad_width(WIDTH);

  // Zero padding can never win a search, so padded indices are never reported.
  logic [PAD_W-1:0] in_pad;
  always_comb begin
    in_pad            = '0;
    in_pad[WIDTH-1:0] = in;
  end

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int N = PAD_W >> l;
    logic [N-1:0] vld;
    logic [l-1:0] msb [N];

    if (l == 1) begin : g_leaf
      for (genvar n = 0; n < N; n++) begin : g_node
        assign vld[n] = in_pad[2*n+1] | in_pad[2*n];
        assign msb[n] = in_pad[2*n+1];
      end
    end else begin : g_merge
      for (genvar n = 0; n < N; n++) begin : g_node
        assign vld[n] = g_lvl[l-1].vld[2*n+1] | g_lvl[l-1].vld[2*n];
        pe_merge_node #(.IDX_W(l-1), .LSB_SIDE(1'b0)) u_msb (
          .valid_hi (g_lvl[l-1].vld[2*n+1]),
          .valid_lo (g_lvl[l-1].vld[2*n]),
          .idx_hi   (g_lvl[l-1].msb[2*n+1]),
          .idx_lo   (g_lvl[l-1].msb[2*n]),
          .idx      (msb[n])
        );
      end
    end

    if (TWO_SIDE) begin : g_two
      logic [l-1:0] lsb [N];
      if (l == 1) begin : g_leaf
        for (genvar n = 0; n < N; n++) begin : g_node
          assign lsb[n] = ~in_pad[2*n];
        end
      end else begin : g_merge
        for (genvar n = 0; n < N; n++) begin : g_node
          pe_merge_node #(.IDX_W(l-1), .LSB_SIDE(1'b1)) u_lsb (
            .valid_hi (g_lvl[l-1].vld[2*n+1]),
            .valid_lo (g_lvl[l-1].vld[2*n]),
            .idx_hi   (g_lvl[l-1].g_two.lsb[2*n+1]),
            .idx_lo   (g_lvl[l-1].g_two.lsb[2*n]),
            .idx      (lsb[n])
          );
        end
      end
    end
  end

  // Stage p0: tree root
  logic [OUT_W-1:0] msb_p0;
  logic [OUT_W-1:0] lsb_p0;
  logic             vld_p0;

  assign vld_p0 = g_lvl[LEVELS].vld[0];
  assign msb_p0 = g_lvl[LEVELS].msb[0];

  // An empty vector drives the LSB tree to all-ones, so it is forced to zero here.
  if (TWO_SIDE) begin : g_lsb_out
    assign lsb_p0 = vld_p0 ? g_lvl[LEVELS].g_two.lsb[0] : '0;
  end else begin : g_lsb_zero
    assign lsb_p0 = '0;
  end

  // Stage p1: optional output register
  if (REGISTERED) begin : g_reg
    logic [OUT_W-1:0] msb_p1;
    logic [OUT_W-1:0] lsb_p1;
    logic             vld_p1;

    always_ff @(posedge clk) begin
      if (rst) begin
        msb_p1 <= '0;
        lsb_p1 <= '0;
        vld_p1 <= 1'b0;
      end else begin
        msb_p1 <= msb_p0;
        lsb_p1 <= lsb_p0;
        vld_p1 <= vld_p0;
      end
    end

    assign out_MSB = msb_p1;
    assign out_LSB = lsb_p1;
    assign valid   = vld_p1;
  end else begin : g_comb
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;

    assign out_MSB = msb_p0;
    assign out_LSB = lsb_p0;
    assign valid   = vld_p0;
  end

endmodule

// File: tb/tb_priority_encoder.sv
// Bench for priority_encoder: vector table, random sweep against a scan model, registered-mode sequences.
module tb_priority_encoder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] in64 = '0;
  logic [5:0]  m64, l64, m64n, l64n;
  logic        v64, v64n;
  logic [4:0]  in5 = '0;
  logic [2:0]  m5, l5;
  logic        v5;
  logic [7:0]  in8 = '0;
  logic [2:0]  m8, l8;
  logic        v8;

  priority_encoder #(.WIDTH(64), .TWO_SIDE(1'b1), .REGISTERED(1'b0)) u_w64 (
    .clk(clk), .rst(rst), .in(in64), .out_MSB(m64), .out_LSB(l64), .valid(v64));
  priority_encoder #(.WIDTH(64), .TWO_SIDE(1'b0), .REGISTERED(1'b0)) u_w64_one (
    .clk(clk), .rst(rst), .in(in64), .out_MSB(m64n), .out_LSB(l64n), .valid(v64n));
  priority_encoder #(.WIDTH(5), .TWO_SIDE(1'b1), .REGISTERED(1'b0)) u_w5 (
    .clk(clk), .rst(rst), .in(in5), .out_MSB(m5), .out_LSB(l5), .valid(v5));
  priority_encoder #(.WIDTH(8), .TWO_SIDE(1'b1), .REGISTERED(1'b1)) u_w8r (
    .clk(clk), .rst(rst), .in(in8), .out_MSB(m8), .out_LSB(l8), .valid(v8));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: plain scans over the bits below w.
  function automatic int ref_msb(input logic [63:0] v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int ref_lsb(input logic [63:0] v, input int w);
    int r = 0;
    for (int i = w - 1; i >= 0; i--) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int ref_vld(input logic [63:0] v, input int w);
    int r = 0;
    for (int i = 0; i < w; i++) if (v[i]) r = 1;
    return r;
  endfunction

  typedef struct {
    logic [63:0] vec;
    int          msb;
    int          lsb;
    int          vld;
  } vec_t;

  vec_t tbl[8];

  initial begin
    logic [63:0] r64;
    logic [7:0]  r8;
    int          em, el, ev;

    tbl[0] = '{64'h0000_0000_0000_0000,  0,  0, 0};
    tbl[1] = '{64'h0000_0001_0000_0000, 32, 32, 1};
    tbl[2] = '{64'hFFFF_FFFF_0000_0000, 63, 32, 1};
    tbl[3] = '{64'h8000_0000_0000_0001, 63,  0, 1};
    tbl[4] = '{64'h0000_0000_0000_0001,  0,  0, 1};
    tbl[5] = '{64'h8000_0000_0000_0000, 63, 63, 1};
    tbl[6] = '{64'h0000_0000_0001_0100, 16,  8, 1};
    tbl[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 63,  0, 1};

    for (int i = 0; i < 8; i++) begin
      in64 = tbl[i].vec;
      #1;
      chk($sformatf("w64_msb[%0d]", i), m64, tbl[i].msb);
      chk($sformatf("w64_lsb[%0d]", i), l64, tbl[i].lsb);
      chk($sformatf("w64_vld[%0d]", i), v64, tbl[i].vld);
      chk($sformatf("one_msb[%0d]", i), m64n, tbl[i].msb);
      chk($sformatf("one_lsb[%0d]", i), l64n, 0);
      chk($sformatf("one_vld[%0d]", i), v64n, tbl[i].vld);
    end

    in5 = 5'b01010;
    #1;
    chk("w5_msb_01010", m5, 3);
    chk("w5_lsb_01010", l5, 1);
    chk("w5_vld_01010", v5, 1);
    in5 = 5'b00000;
    #1;
    chk("w5_msb_zero", m5, 0);
    chk("w5_lsb_zero", l5, 0);
    chk("w5_vld_zero", v5, 0);

    for (int i = 0; i < 300; i++) begin
      r64  = {$urandom, $urandom} >> $urandom_range(63, 0);
      if ($urandom_range(1, 0) == 1) r64 = r64 & {$urandom, $urandom};
      in64 = r64;
      in5  = 5'($urandom_range(31, 0));
      #1;
      chk("rnd_w64_msb", m64, ref_msb(in64, 64));
      chk("rnd_w64_lsb", l64, ref_lsb(in64, 64));
      chk("rnd_w64_vld", v64, ref_vld(in64, 64));
      chk("rnd_one_lsb", l64n, 0);
      chk("rnd_one_msb", m64n, ref_msb(in64, 64));
      chk("rnd_w5_msb", m5, ref_msb({59'd0, in5}, 5));
      chk("rnd_w5_lsb", l5, ref_lsb({59'd0, in5}, 5));
      chk("rnd_w5_vld", v5, ref_vld({59'd0, in5}, 5));
    end

    // Registered instance: reset dominates a non-zero input.
    @(negedge clk);
    rst = 1'b1;
    in8 = 8'hFF;
    @(posedge clk);
    #1;
    chk("reg_rst_msb", m8, 0);
    chk("reg_rst_lsb", l8, 0);
    chk("reg_rst_vld", v8, 0);

    @(negedge clk);
    rst = 1'b0;
    in8 = 8'h90;
    #1;
    chk("reg_latency_vld", v8, 0);
    @(posedge clk);
    #1;
    chk("reg_90_msb", m8, 7);
    chk("reg_90_lsb", l8, 4);
    chk("reg_90_vld", v8, 1);

    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("reg_midrst_msb", m8, 0);
    chk("reg_midrst_lsb", l8, 0);
    chk("reg_midrst_vld", v8, 0);

    @(negedge clk);
    rst = 1'b0;
    in8 = 8'h03;
    @(posedge clk);
    #1;
    chk("reg_first_msb", m8, 1);
    chk("reg_first_lsb", l8, 0);
    chk("reg_first_vld", v8, 1);

    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      r8  = 8'($urandom_range(255, 0));
      if ($urandom_range(7, 0) == 0) r8 = 8'h00;
      in8 = r8;
      rst = ($urandom_range(15, 0) == 0);
      em  = rst ? 0 : ref_msb({56'd0, r8}, 8);
      el  = rst ? 0 : ref_lsb({56'd0, r8}, 8);
      ev  = rst ? 0 : ref_vld({56'd0, r8}, 8);
      @(posedge clk);
      #1;
      chk("rnd_reg_msb", m8, em);
      chk("rnd_reg_lsb", l8, el);
      chk("rnd_reg_vld", v8, ev);
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
